// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Main instruction decoder for the ID stage of the 5-stage RV32I pipeline.
// The 7-bit opcode is decoded combinationally into datapath controls, and the
// same bundle is captured into the ID/EX control register, which supports
// stall (hold) and flush (load NOP). Unknown opcodes decode to a NOP bundle
// and raise illegal_instr.
//
// Ports
//   clk, rst_n           pipeline clock (rising edge), async active-low reset
//   opcode[6:0]          instr[6:0] of the ID-stage instruction
//   stall                hold the ID/EX control register
//   flush                load a NOP bundle into the ID/EX control register
//   reg_write_en .. alu_op_control[1:0]   combinational decode
//   illegal_instr        opcode not in the supported table
//   ex_*                 registered (ID/EX) copies of the decode
// ---------------------------------------------------------------------------
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       stall,
  input  logic       flush,
  output logic       reg_write_en,
  output logic       mem_read_en,
  output logic       mem_write_en,
  output logic       mem_to_reg,
  output logic       alu_src_select,
  output logic       branch_en,
  output logic [1:0] alu_op_control,
  output logic       illegal_instr,
  output logic       ex_reg_write_en,
  output logic       ex_mem_read_en,
  output logic       ex_mem_write_en,
  output logic       ex_mem_to_reg,
  output logic       ex_alu_src_select,
  output logic       ex_branch_en,
  output logic [1:0] ex_alu_op_control
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

  ctrl_t dec;
  ctrl_t ex_q;
  logic  illegal;

  // Opcode decode. An X/Z opcode matches no item and falls into the default
  // NOP/illegal branch. During reset everything, including illegal, is 0.
  always_comb begin
    dec     = NOP_CTRL;
    illegal = 1'b0;
    if (rst_n) begin
      case (opcode)
        OP_RTYPE:  dec = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                           mem_to_reg: 1'b0, alu_src: 1'b0, branch: 1'b0,
                           alu_op: 2'b10};
        OP_IALU:   dec = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                           mem_to_reg: 1'b0, alu_src: 1'b1, branch: 1'b0,
                           alu_op: 2'b11};
        OP_LOAD:   dec = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                           mem_to_reg: 1'b1, alu_src: 1'b1, branch: 1'b0,
                           alu_op: 2'b00};
        OP_STORE:  dec = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1,
                           mem_to_reg: 1'b0, alu_src: 1'b1, branch: 1'b0,
                           alu_op: 2'b00};
        OP_BRANCH: dec = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                           mem_to_reg: 1'b0, alu_src: 1'b0, branch: 1'b1,
                           alu_op: 2'b01};
        default: begin
          dec     = NOP_CTRL;
          illegal = 1'b1;
        end
      endcase
    end
  end

  // ID/EX control register: flush beats stall, so a flushed slot is always a
  // bubble. Illegal opcodes already decode to NOP, so they enter EX as NOPs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= NOP_CTRL;
    end else if (flush) begin
      ex_q <= NOP_CTRL;
    end else if (!stall) begin
      ex_q <= dec;
    end
  end

  assign reg_write_en      = dec.reg_write;
  assign mem_read_en       = dec.mem_read;
  assign mem_write_en      = dec.mem_write;
  assign mem_to_reg        = dec.mem_to_reg;
  assign alu_src_select    = dec.alu_src;
  assign branch_en         = dec.branch;
  assign alu_op_control    = dec.alu_op;
  assign illegal_instr     = illegal;

  assign ex_reg_write_en   = ex_q.reg_write;
  assign ex_mem_read_en    = ex_q.mem_read;
  assign ex_mem_write_en   = ex_q.mem_write;
  assign ex_mem_to_reg     = ex_q.mem_to_reg;
  assign ex_alu_src_select = ex_q.alu_src;
  assign ex_branch_en      = ex_q.branch;
  assign ex_alu_op_control = ex_q.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench for control_unit. The driver applies one stimulus per
// clock cycle and pushes the reference model's expected combinational and
// ID/EX outputs into a queue; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       stall;
  logic       flush;
  logic       reg_write_en, mem_read_en, mem_write_en, mem_to_reg;
  logic       alu_src_select, branch_en, illegal_instr;
  logic [1:0] alu_op_control;
  logic       ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_mem_to_reg;
  logic       ex_alu_src_select, ex_branch_en;
  logic [1:0] ex_alu_op_control;

  control_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode           (opcode),
    .stall            (stall),
    .flush            (flush),
    .reg_write_en     (reg_write_en),
    .mem_read_en      (mem_read_en),
    .mem_write_en     (mem_write_en),
    .mem_to_reg       (mem_to_reg),
    .alu_src_select   (alu_src_select),
    .branch_en        (branch_en),
    .alu_op_control   (alu_op_control),
    .illegal_instr    (illegal_instr),
    .ex_reg_write_en  (ex_reg_write_en),
    .ex_mem_read_en   (ex_mem_read_en),
    .ex_mem_write_en  (ex_mem_write_en),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .ex_alu_src_select(ex_alu_src_select),
    .ex_branch_en     (ex_branch_en),
    .ex_alu_op_control(ex_alu_op_control)
  );

  // Reference decode table, column order RegWr MemRd MemWr MemToReg ALUSrc
  // Branch ALUOp[1:0].
  localparam logic [6:0] REF_OPS [5] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                         7'b0100011, 7'b1100011};
  localparam logic [7:0] REF_CTL [5] = '{8'b1000_0010, 8'b1000_1011, 8'b1101_1000,
                                         8'b0010_1000, 8'b0000_0101};

  typedef struct packed {
    logic [8:0] comb;
    logic [7:0] ex;
  } expect_t;

  expect_t exp_q[$];
  logic [7:0] model_ex;
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table lookup: {controls, illegal}; everything 0 while in reset.
  function automatic logic [8:0] ref_decode(input logic [6:0] opc, input logic rst_ok);
    logic [8:0] r;
    r = {8'h00, 1'b1};
    for (int i = 0; i < 5; i++)
      if (opc == REF_OPS[i]) r = {REF_CTL[i], 1'b0};
    if (!rst_ok) r = '0;
    return r;
  endfunction

  // One cycle: at the rising edge the model register absorbs the inputs of
  // the finished cycle, then new inputs are driven and the expectation queued.
  task automatic applyStimulus(input logic [6:0] opc, input logic st,
                               input logic fl, input logic rst);
    logic [8:0] d;
    @(posedge clk);
    d = ref_decode(opcode, rst_n);
    if (!rst_n)      model_ex = '0;
    else if (flush)  model_ex = '0;
    else if (!stall) model_ex = d[8:1];
    #1;
    opcode = opc;
    stall  = st;
    flush  = fl;
    rst_n  = rst;
    if (!rst) model_ex = '0;
    exp_q.push_back('{comb: ref_decode(opc, rst), ex: model_ex});
  endtask

  task automatic checkOutput(input string name, input logic [8:0] actual,
                             input logic [8:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%b required=%b", name, $time, actual, required);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare on the
  // falling edge, away from the capturing edge.
  always @(negedge clk) begin
    expect_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("comb_decode",
                  {reg_write_en, mem_read_en, mem_write_en, mem_to_reg,
                   alu_src_select, branch_en, alu_op_control, illegal_instr},
                  e.comb);
      checkOutput("ex_bundle",
                  {1'b0, ex_reg_write_en, ex_mem_read_en, ex_mem_write_en,
                   ex_mem_to_reg, ex_alu_src_select, ex_branch_en, ex_alu_op_control},
                  {1'b0, e.ex});
      checkOutput("invariant_mem",
                  {7'b0, mem_read_en & mem_write_en, mem_to_reg & ~mem_read_en},
                  9'b0);
    end
  end

  initial begin
    logic [6:0] opc;
    int         waited;
    rst_n    = 1'b0;
    opcode   = 7'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    model_ex = '0;

    // reset state, then release
    applyStimulus(7'b0110011, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b0110011, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b0110011, 1'b0, 1'b0, 1'b1);
    // each listed opcode and an illegal one, each captured at the next edge
    applyStimulus(7'b0010011, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0000011, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0100011, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b1100011, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b1111111, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0000000, 1'b0, 1'b0, 1'b1);
    // load latched, then held through two stalled edges, then stall+flush
    applyStimulus(7'b0000011, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0100011, 1'b1, 1'b0, 1'b1);
    applyStimulus(7'b0100011, 1'b1, 1'b0, 1'b1);
    applyStimulus(7'b0100011, 1'b1, 1'b1, 1'b1);
    applyStimulus(7'b0110011, 1'b0, 1'b0, 1'b1);
    // asynchronous reset between edges, release, then capture
    applyStimulus(7'b0110011, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b0010011, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0000011, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1) opc = REF_OPS[$urandom_range(4, 0)];
      else                           opc = 7'($urandom);
      applyStimulus(opc, $urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0,
                    $urandom_range(29, 0) != 0);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
